// File: rtl/mesi_pkg.sv
// Shared MESI encodings, snooped bus commands and snoop-controller FSM states.
package mesi_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_state_t;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'b00,
    CMD_BUSRD   = 2'b01,
    CMD_BUSRDX  = 2'b10,
    CMD_BUSUPGR = 2'b11
  } bus_cmd_t;

  typedef enum logic [2:0] {
    SNP_IDLE,
    SNP_REQ,
    SNP_CMP,
    SNP_WB,
    SNP_UPD,
    SNP_RESP
  } snp_fsm_t;

endpackage

// File: rtl/mesi_snoop_next.sv
// Combinational MESI snoop downgrade: current line state and bus command in,
// new line state, flush-required and protocol-error flags out.
module mesi_snoop_next
  import mesi_pkg::*;
(
  input  mesi_state_t cur_state,
  input  bus_cmd_t    cmd,
  output mesi_state_t next_state,
  output logic        flush,
  output logic        err
);

  always_comb begin
    next_state = cur_state;
    flush      = 1'b0;
    err        = 1'b0;
    case (cmd)
      CMD_BUSRD: begin
        if (cur_state != MESI_I) next_state = MESI_S;
        flush = (cur_state == MESI_M);
      end
      CMD_BUSRDX: begin
        next_state = MESI_I;
        flush      = (cur_state == MESI_M);
      end
      CMD_BUSUPGR: begin
        // A Modified line cannot legally see an upgrade; drop it without flushing.
        next_state = MESI_I;
        err        = (cur_state == MESI_M);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mesi_snoop_ctrl.sv
// Set-associative MESI snooper: accepts one bus transaction at a time, looks up
// the indexed set through the shared tag/state array and downgrades the hit way.
module mesi_snoop_ctrl
  import mesi_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned INDEX_W  = 6,
  parameter int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  parameter int unsigned WAYS     = 4,
  parameter int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bus_valid,
  output logic                    bus_ready,
  input  logic [ADDR_W-1:0]       bus_addr,
  input  logic [1:0]              bus_cmd,
  output logic                    arr_req,
  input  logic                    arr_gnt,
  output logic [INDEX_W-1:0]      arr_index,
  input  logic [WAYS*TAG_W-1:0]   arr_rd_tag,
  input  logic [WAYS*2-1:0]       arr_rd_state,
  output logic                    arr_we,
  output logic [WAY_W-1:0]        arr_way,
  output logic [1:0]              arr_wr_state,
  output logic                    wb_req,
  output logic [INDEX_W-1:0]      wb_index,
  output logic [WAY_W-1:0]        wb_way,
  input  logic                    wb_ack,
  output logic                    snp_done,
  output logic                    snp_hit,
  output logic                    snp_shared,
  output logic                    snp_dirty,
  output logic                    proto_err
);

  snp_fsm_t           state, state_nxt;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] index_q;
  bus_cmd_t           cmd_q;
  logic [WAY_W-1:0]   way_q;
  mesi_state_t        wr_state_q;
  logic               hit_q, shared_q, dirty_q;

  logic               any_hit, multi_hit;
  logic [WAY_W-1:0]   hit_way;
  mesi_state_t        hit_state;
  mesi_state_t        new_state;
  logic               need_flush, upd_err;

  logic [OFFSET_W-1:0] unused_offset;
  assign unused_offset = bus_addr[OFFSET_W-1:0];

  // Lowest-numbered valid way with a matching tag wins; any further match is flagged.
  always_comb begin
    mesi_state_t way_st;
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    hit_way   = '0;
    hit_state = MESI_I;
    for (int unsigned w = 0; w < WAYS; w++) begin
      way_st = mesi_state_t'(arr_rd_state[2*w +: 2]);
      if (way_st != MESI_I && arr_rd_tag[TAG_W*w +: TAG_W] == tag_q) begin
        if (any_hit) begin
          multi_hit = 1'b1;
        end else begin
          any_hit   = 1'b1;
          hit_way   = WAY_W'(w);
          hit_state = way_st;
        end
      end
    end
  end

  mesi_snoop_next u_next (
    .cur_state  (hit_state),
    .cmd        (cmd_q),
    .next_state (new_state),
    .flush      (need_flush),
    .err        (upd_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SNP_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus_ready = 1'b0;
    arr_req   = 1'b0;
    arr_we    = 1'b0;
    wb_req    = 1'b0;
    snp_done  = 1'b0;
    proto_err = 1'b0;
    case (state)
      SNP_IDLE: begin
        bus_ready = 1'b1;
        if (bus_valid) begin
          state_nxt = (bus_cmd_t'(bus_cmd) == CMD_NOP) ? SNP_RESP : SNP_REQ;
        end
      end
      SNP_REQ: begin
        arr_req = 1'b1;
        if (arr_gnt) state_nxt = SNP_CMP;
      end
      SNP_CMP: begin
        arr_req   = 1'b1;
        proto_err = multi_hit | (any_hit & upd_err);
        if (!any_hit)       state_nxt = SNP_RESP;
        else if (need_flush) state_nxt = SNP_WB;
        else                 state_nxt = SNP_UPD;
      end
      SNP_WB: begin
        arr_req = 1'b1;
        wb_req  = 1'b1;
        if (wb_ack) state_nxt = SNP_UPD;
      end
      SNP_UPD: begin
        arr_req   = 1'b1;
        arr_we    = 1'b1;
        state_nxt = SNP_RESP;
      end
      SNP_RESP: begin
        snp_done  = 1'b1;
        state_nxt = SNP_IDLE;
      end
      default: state_nxt = SNP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= '0;
      index_q    <= '0;
      cmd_q      <= CMD_NOP;
      way_q      <= '0;
      wr_state_q <= MESI_I;
      hit_q      <= 1'b0;
      shared_q   <= 1'b0;
      dirty_q    <= 1'b0;
    end else begin
      if (state == SNP_IDLE && bus_valid) begin
        tag_q    <= bus_addr[ADDR_W-1 -: TAG_W];
        index_q  <= bus_addr[OFFSET_W +: INDEX_W];
        cmd_q    <= bus_cmd_t'(bus_cmd);
        hit_q    <= 1'b0;
        shared_q <= 1'b0;
        dirty_q  <= 1'b0;
      end
      if (state == SNP_CMP && any_hit) begin
        way_q      <= hit_way;
        wr_state_q <= new_state;
        hit_q      <= 1'b1;
        shared_q   <= (new_state == MESI_S);
        dirty_q    <= need_flush;
      end
    end
  end

  assign arr_index    = index_q;
  assign arr_way      = way_q;
  assign arr_wr_state = wr_state_q;
  assign wb_index     = index_q;
  assign wb_way       = way_q;
  assign snp_hit      = snp_done & hit_q;
  assign snp_shared   = snp_done & shared_q;
  assign snp_dirty    = snp_done & dirty_q;

endmodule

// File: tb/tb_mesi_snoop_ctrl.sv
// Scoreboard bench for mesi_snoop_ctrl: an array/arbiter/write-back environment,
// a rule-level reference model feeding expectations, and an independent monitor.
module tb_mesi_snoop_ctrl;
  import mesi_pkg::*;

  localparam int ADDR_W = 32, OFFSET_W = 6, INDEX_W = 6, TAG_W = 20, WAYS = 4, WAY_W = 2;
  localparam int SETS = 64;

  logic clk = 1'b0, rst = 1'b1;
  logic bus_valid = 1'b0, bus_ready;
  logic [ADDR_W-1:0] bus_addr = '0;
  logic [1:0] bus_cmd = '0;
  logic arr_req, arr_gnt, arr_we, wb_req, wb_ack;
  logic [INDEX_W-1:0] arr_index, wb_index;
  logic [WAYS*TAG_W-1:0] arr_rd_tag;
  logic [WAYS*2-1:0] arr_rd_state;
  logic [WAY_W-1:0] arr_way, wb_way;
  logic [1:0] arr_wr_state;
  logic snp_done, snp_hit, snp_shared, snp_dirty, proto_err;

  mesi_snoop_ctrl #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_cmd(bus_cmd), .arr_req(arr_req), .arr_gnt(arr_gnt), .arr_index(arr_index),
    .arr_rd_tag(arr_rd_tag), .arr_rd_state(arr_rd_state), .arr_we(arr_we), .arr_way(arr_way),
    .arr_wr_state(arr_wr_state), .wb_req(wb_req), .wb_index(wb_index), .wb_way(wb_way),
    .wb_ack(wb_ack), .snp_done(snp_done), .snp_hit(snp_hit), .snp_shared(snp_shared),
    .snp_dirty(snp_dirty), .proto_err(proto_err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int lat; bit hit; bit shared; bit dirty; bit we; int we_way; int we_state;
    bit wb; int idx; int err; int acc_cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0, passes = 0;
  int gnt_delay = 0, wb_delay = 0;

  logic [TAG_W-1:0] mtag [SETS][WAYS];
  logic [1:0]       mst  [SETS][WAYS];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Environment: arbiter, array read port, write-back responder, array storage.
  initial begin
    int gcnt = 0, wcnt = 0;
    bit granted = 0;
    arr_gnt = 1'b0; wb_ack = 1'b0; arr_rd_tag = '0; arr_rd_state = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arr_gnt = 1'b0; wb_ack = 1'b0; gcnt = 0; wcnt = 0; granted = 0;
      end else begin
        if (arr_req) begin
          if (gcnt < gnt_delay) begin
            gcnt++; arr_gnt = 1'b0;
          end else begin
            arr_gnt = 1'b1;
            if (!granted) begin
              granted = 1;
              for (int w = 0; w < WAYS; w++) begin
                arr_rd_tag[w*TAG_W +: TAG_W] = mtag[arr_index][w];
                arr_rd_state[2*w +: 2]       = mst[arr_index][w];
              end
            end
          end
        end else begin
          arr_gnt = 1'b0; gcnt = 0; granted = 0;
          for (int w = 0; w < WAYS; w++) begin
            arr_rd_tag[w*TAG_W +: TAG_W] = TAG_W'($urandom);
            arr_rd_state[2*w +: 2]       = 2'($urandom);
          end
        end
        if (wb_req) begin
          if (wcnt < wb_delay) begin wcnt++; wb_ack = 1'b0; end
          else wb_ack = 1'b1;
        end else begin
          wb_ack = 1'b0; wcnt = 0;
        end
        if (arr_we) mst[arr_index][arr_way] = arr_wr_state;
      end
    end
  end

  // Monitor: accumulates array/write-back activity and checks it at each snp_done.
  initial begin
    int we_cnt = 0, we_way = 0, we_st = 0, err_cnt = 0, wb_i = 0, wb_w = 0;
    bit wb_seen = 0, wb_unstable = 0, idx_bad = 0, ready_bad = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        we_cnt = 0; err_cnt = 0; wb_seen = 0; wb_unstable = 0; idx_bad = 0; ready_bad = 0;
      end else begin
        if (arr_req && sb.size() > 0 && int'(arr_index) != sb[0].idx) idx_bad = 1;
        if (bus_ready && sb.size() > 0) ready_bad = 1;
        if (arr_we) begin we_cnt++; we_way = int'(arr_way); we_st = int'(arr_wr_state); end
        if (wb_req) begin
          if (!wb_seen) begin wb_i = int'(wb_index); wb_w = int'(wb_way); end
          else if (int'(wb_index) != wb_i || int'(wb_way) != wb_w) wb_unstable = 1;
          wb_seen = 1;
        end
        if (proto_err) err_cnt++;
        if (snp_done) begin
          if (sb.size() == 0) begin
            chk("spurious_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("latency", cyc - e.acc_cyc + 1, e.lat);
            chk("snp_hit", snp_hit, e.hit);
            chk("snp_shared", snp_shared, e.shared);
            chk("snp_dirty", snp_dirty, e.dirty);
            chk("arr_we_count", we_cnt, e.we ? 1 : 0);
            if (e.we) begin
              chk("arr_way", we_way, e.we_way);
              chk("arr_wr_state", we_st, e.we_state);
            end
            chk("wb_req_seen", wb_seen, e.wb);
            if (e.wb) begin
              chk("wb_index", wb_i, e.idx);
              chk("wb_way", wb_w, e.we_way);
              chk("wb_stable", wb_unstable, 0);
            end
            chk("proto_err_pulses", err_cnt, e.err);
            chk("arr_index", idx_bad, 0);
            chk("bus_ready_busy", ready_bad, 0);
          end
          we_cnt = 0; err_cnt = 0; wb_seen = 0; wb_unstable = 0; idx_bad = 0; ready_bad = 0;
        end
      end
    end
  end

  // Reference model: MESI rules applied to the environment's current array contents.
  function automatic exp_t predict(input logic [ADDR_W-1:0] a, input logic [1:0] c,
                                   input int gd, input int wd);
    exp_t e;
    int idx = int'(a[11:6]);
    logic [TAG_W-1:0] t = a[31:12];
    int nmatch = 0, way = 0, st = 0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (mst[idx][w] != 2'b00 && mtag[idx][w] == t) begin nmatch++; way = w; st = int'(mst[idx][w]); end
    e = '{lat: 1, hit: 0, shared: 0, dirty: 0, we: 0, we_way: 0, we_state: 0,
          wb: 0, idx: idx, err: 0, acc_cyc: 0};
    if (c == 2'b00) return e;
    if (nmatch == 0) begin e.lat = 3 + gd; return e; end
    e.hit = 1; e.we = 1; e.we_way = way;
    e.we_state = (c == 2'b01) ? 1 : 0;
    e.dirty = (st == 3) && (c != 2'b11);
    e.wb = e.dirty;
    e.shared = (e.we_state == 1);
    e.err = (nmatch > 1 || (c == 2'b11 && st == 3)) ? 1 : 0;
    e.lat = 4 + gd + (e.dirty ? wd + 1 : 0);
    return e;
  endfunction

  bit abort = 0;

  task automatic issue(input logic [ADDR_W-1:0] a, input logic [1:0] c, input int gd, input int wd);
    exp_t e;
    int n = 0;
    while (!bus_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus_ready) begin chk("bus_ready_timeout", 0, 1); abort = 1; return; end
    gnt_delay = gd; wb_delay = wd;
    e = predict(a, c, gd, wd);
    bus_valid = 1'b1; bus_addr = a; bus_cmd = c;
    @(posedge clk); #1;
    e.acc_cyc = cyc;
    sb.push_back(e);
    bus_valid = 1'b0; bus_addr = ADDR_W'($urandom); bus_cmd = 2'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin chk("snp_done_timeout", 0, 1); sb.delete(); abort = 1; end
  endtask

  task automatic txn(input logic [ADDR_W-1:0] a, input logic [1:0] c, input int gd, input int wd);
    if (abort) return;
    issue(a, c, gd, wd);
    if (!abort) wait_done();
    @(negedge clk);
  endtask

  task automatic clear_set(input int idx);
    for (int w = 0; w < WAYS; w++) begin mtag[idx][w] = '0; mst[idx][w] = 2'b00; end
  endtask

  initial begin
    for (int s = 0; s < SETS; s++) clear_set(s);
    #12;
    chk("rst_bus_ready", bus_ready, 1);
    chk("rst_arr_req", arr_req, 0);
    chk("rst_wb_req", wb_req, 0);
    chk("rst_arr_we", arr_we, 0);
    chk("rst_snp_done", snp_done, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_arr_index", arr_index, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    mtag[5][2] = 20'hABCDE; mst[5][2] = 2'b10;
    txn(32'hABCDE140, 2'b01, 0, 0);
    chk("set5_way2_state", mst[5][2], 2'b01);

    clear_set(5); mtag[5][1] = 20'hABCDE; mst[5][1] = 2'b11;
    txn(32'hABCDE140, 2'b10, 0, 3);

    clear_set(7); mtag[7][0] = 20'hABCDE; mst[7][0] = 2'b11;
    txn(32'h111111C0, 2'b01, 0, 0);
    txn(32'h11111200, 2'b01, 0, 0);

    clear_set(9); mtag[9][3] = 20'h0F00D; mst[9][3] = 2'b11;
    txn(32'h0F00D240, 2'b11, 0, 0);

    clear_set(10); mtag[10][0] = 20'h12345; mst[10][0] = 2'b01;
    mtag[10][3] = 20'h12345; mst[10][3] = 2'b10;
    txn(32'h12345280, 2'b01, 0, 0);

    mtag[11][2] = 20'h55555; mst[11][2] = 2'b01;
    txn(32'h555552C0, 2'b11, 5, 0);
    txn(32'h555552C0, 2'b00, 0, 0);

    // Reset while a write-back is outstanding.
    if (!abort) begin
      clear_set(5); mtag[5][1] = 20'hABCDE; mst[5][1] = 2'b11;
      issue(32'hABCDE140, 2'b10, 0, 50);
      begin
        int n = 0;
        while (!wb_req && n < 50) begin @(negedge clk); n++; end
      end
      chk("wb_req_before_rst", wb_req, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_wb_req", wb_req, 0);
      chk("rst_async_arr_req", arr_req, 0);
      chk("rst_async_bus_ready", bus_ready, 1);
      sb.delete();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      chk("rst_no_partial_write", mst[5][1], 2'b11);
      @(negedge clk);
      txn(32'hABCDE140, 2'b01, 1, 1);
    end

    for (int i = 0; i < 150 && !abort; i++) begin
      logic [TAG_W-1:0] pool [3];
      int idx = $urandom_range(0, SETS - 1);
      pool[0] = 20'h12345; pool[1] = 20'h12346; pool[2] = 20'hABCDE;
      if ($urandom_range(0, 1) == 1)
        for (int w = 0; w < WAYS; w++) begin
          mtag[idx][w] = pool[$urandom_range(0, 2)];
          mst[idx][w]  = 2'($urandom);
        end
      txn({pool[$urandom_range(0, 2)], 6'(idx), 6'($urandom)}, 2'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
